display_scan_ctrl: RTL and testbench

Round-robin scan scheduler for the multiplexed common-anode seven-segment displays. It owns the shared segment bus and the PNP digit-select lines. Each enabled digit gets a fixed-length time slot containing dead-time blanking, a brightness-scaled on-window and a dark remainder. It feeds the digit value to the existing `seven_segment` decoder and replaces the free-running toggle divider with a sequenced, ghost-free controller.

---
 rtl/display_pkg.sv | 15 +
 rtl/rr_next_digit.sv | 37 +++
 rtl/display_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the
// multiplexed seven-segment scan controller.
package display_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      ON,
      OFF
   } scan_state_t;

   localparam int DIGIT_W    = 4;
   localparam int BRIGHT_MAX = 15;

endpackage

// File: rtl/rr_next_digit.sv
// rr_next_digit: combinational round-robin search for the next
// enabled digit strictly after cur_i, wrapping back to the lowest.
module rr_next_digit #(
   parameter int NUM_DIGITS = 2,
   parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
   input  logic [NUM_DIGITS-1:0] en_i,
   input  logic [IDX_W-1:0]      cur_i,
   output logic [IDX_W-1:0]      next_o,
   output logic                  valid_o,
   output logic                  wrap_o
);

   logic [IDX_W-1:0] low;
   logic [IDX_W-1:0] high;
   logic             found_high;

   // lowest enabled index overall, and lowest enabled index above cur_i
   always_comb begin
      low        = '0;
      high       = '0;
      found_high = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (en_i[i]) begin
            low = IDX_W'(i);
            if (IDX_W'(i) > cur_i) begin
               high       = IDX_W'(i);
               found_high = 1'b1;
            end
         end
      end
      valid_o = |en_i;
      wrap_o  = !found_high;
      next_o  = found_high ? high : low;
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: slot-based scan of common-anode digits with
// dead-time blanking, brightness-scaled on-window and dark remainder.
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int NUM_DIGITS   = 2,
   parameter int BLANK_CYCLES = 60,
   parameter int STEP_CYCLES  = 396
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]         digit_en,
   input  logic [3:0]                    brightness,
   output logic [DIGIT_W-1:0]            digit_val,
   output logic [NUM_DIGITS-1:0]         select,
   output logic                          frame_tick
);

   localparam int SLOT  = BLANK_CYCLES + BRIGHT_MAX * STEP_CYCLES;
   localparam int CNT_W = $clog2(SLOT);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT - 1);

   scan_state_t          state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [3:0]            bright_q, bright_d;
   logic [DIGIT_W-1:0]    val_q, val_d;
   logic [NUM_DIGITS-1:0] sel_q, sel_d;
   logic                  tick_q, tick_d;

   logic [IDX_W-1:0]      rr_cur;
   logic [IDX_W-1:0]      rr_next;
   logic                  rr_valid;
   logic                  rr_wrap;
   logic                  start;
   int                    on_end;

   rr_next_digit #(
      .NUM_DIGITS (NUM_DIGITS),
      .IDX_W      (IDX_W)
   ) u_rr (
      .en_i    (digit_en),
      .cur_i   (rr_cur),
      .next_o  (rr_next),
      .valid_o (rr_valid),
      .wrap_o  (rr_wrap)
   );

   // state, slot counter, shadows and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         bright_q <= '0;
         val_q    <= '0;
         sel_q    <= '1;
         tick_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         bright_q <= bright_d;
         val_q    <= val_d;
         sel_q    <= sel_d;
         tick_q   <= tick_d;
      end
   end

   // next-state: slot sequencing, phase selection and slot start capture
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      bright_d = bright_q;
      val_d    = val_q;
      tick_d   = 1'b0;
      start    = 1'b0;
      on_end   = BLANK_CYCLES + int'(bright_q) * STEP_CYCLES;
      // from IDLE, searching after the top index yields the lowest one
      rr_cur   = (state_q == IDLE) ? IDX_W'(NUM_DIGITS - 1) : idx_q;

      unique case (state_q)
         IDLE: begin
            start = rr_valid;
         end
         default: begin
            if (cnt_q == CNT_LAST) begin
               if (rr_valid) begin
                  start  = 1'b1;
                  tick_d = rr_wrap;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (state_q == OFF || !digit_en[idx_q]) begin
                  state_d = OFF;
               end else if (int'(cnt_d) < BLANK_CYCLES) begin
                  state_d = BLANK;
               end else if (int'(cnt_d) < on_end) begin
                  state_d = ON;
               end else begin
                  state_d = OFF;
               end
            end
         end
      endcase

      if (start) begin
         state_d  = BLANK;
         cnt_d    = '0;
         idx_d    = rr_next;
         bright_d = brightness;
         val_d    = digits_in[int'(rr_next)*DIGIT_W +: DIGIT_W];
      end

      sel_d = '1;
      if (state_d == ON) begin
         sel_d[idx_d] = 1'b0;
      end
   end

   assign digit_val  = val_q;
   assign select     = sel_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: slot-level reference model with per-cycle
// compare, directed scenarios with literal pins, then random stimulus.
module tb_display_scan_ctrl;

   localparam int N    = 2;
   localparam int B    = 4;
   localparam int S    = 2;
   localparam int SLOT = B + 15 * S;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [4*N-1:0] digits_in = '0;
   logic [N-1:0]   digit_en = '0;
   logic [3:0]     brightness = '0;
   logic [3:0]     digit_val;
   logic [N-1:0]   select;
   logic           frame_tick;

   int tests = 0;
   int fails = 0;

   display_scan_ctrl #(
      .NUM_DIGITS   (N),
      .BLANK_CYCLES (B),
      .STEP_CYCLES  (S)
   ) dut (
      .clk        (clk),
      .reset      (reset_n),
      .digits_in  (digits_in),
      .digit_en   (digit_en),
      .brightness (brightness),
      .digit_val  (digit_val),
      .select     (select),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // reference model: one slot of SLOT cycles per enabled digit
   bit       m_act = 0;
   int       m_idx = 0;
   int       m_cnt = 0;
   int       m_bright = 0;
   logic [3:0] m_val = '0;
   bit       m_tick = 0;
   bit       m_kill = 0;

   function automatic int next_en(input int cur, input logic [N-1:0] en);
      for (int k = 1; k <= N; k++) begin
         if (en[(cur + k) % N]) return (cur + k) % N;
      end
      return -1;
   endfunction

   task automatic begin_slot(input int j);
      m_act    = 1;
      m_idx    = j;
      m_cnt    = 0;
      m_kill   = 0;
      m_bright = int'(brightness);
      m_val    = digits_in[4*j +: 4];
   endtask

   always @(posedge clk) begin
      int j;
      if (!reset_n) begin
         m_act = 0; m_idx = 0; m_cnt = 0; m_bright = 0;
         m_val = '0; m_tick = 0; m_kill = 0;
      end else if (!m_act) begin
         m_tick = 0;
         if (digit_en != '0) begin_slot(next_en(N - 1, digit_en));
      end else if (m_cnt == SLOT - 1) begin
         j = next_en(m_idx, digit_en);
         if (j < 0) begin
            m_act  = 0;
            m_tick = 0;
         end else begin
            m_tick = (j <= m_idx);
            begin_slot(j);
         end
      end else begin
         m_tick = 0;
         if (!digit_en[m_idx]) m_kill = 1;
         m_cnt++;
      end
   end

   // per-cycle compare against the model
   always @(negedge clk) begin
      logic [N-1:0] es;
      es = '1;
      if (m_act && !m_kill && m_cnt >= B && m_cnt < B + m_bright * S)
         es[m_idx] = 1'b0;
      check("select", 32'(select), 32'(es));
      check("digit_val", 32'(digit_val), 32'(m_val));
      check("frame_tick", 32'(frame_tick), 32'(m_tick));
      check("one_digit_max", 32'($countones(~select) <= 1), 32'd1);
   end

   task automatic wait_tick();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_tick && n < 300);
      check("tick_seen", 32'(frame_tick), 32'd1);
   endtask

   task automatic window(input string name, input int len,
                         input int exp_low, input int exp_ticks);
      int low = 0;
      int tk = 0;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         if (select != '1) low++;
         if (frame_tick) tk++;
      end
      check({name, "_on_cycles"}, 32'(low), 32'(exp_low));
      check({name, "_ticks"}, 32'(tk), 32'(exp_ticks));
   endtask

   initial begin
      int tk;
      repeat (3) @(negedge clk);
      check("rst_select", 32'(select), 32'h3);
      check("rst_digit_val", 32'(digit_val), 32'h0);
      check("rst_tick", 32'(frame_tick), 32'h0);

      // full brightness
      digits_in  = 8'h73;
      digit_en   = 2'b11;
      brightness = 4'd15;
      reset_n    = 1'b1;
      @(negedge clk);
      check("first_slot_d0", 32'(digit_val), 32'h3);
      wait_tick();
      window("full", 2 * SLOT, 60, 1);

      // zero and partial brightness
      brightness = 4'd0;
      wait_tick();
      window("bright0", 2 * SLOT, 0, 1);
      brightness = 4'd5;
      wait_tick();
      window("bright5", 2 * SLOT, 20, 1);

      // single digit
      digit_en   = 2'b10;
      brightness = 4'd8;
      wait_tick();
      window("single", 2 * SLOT, 32, 2);
      check("single_val", 32'(digit_val), 32'h7);

      // disable mid-ON, then re-enable digit 0
      digit_en   = 2'b11;
      brightness = 4'd15;
      wait_tick();
      repeat (6) @(negedge clk);
      digit_en = 2'b00;
      @(negedge clk);
      check("dis_sel_off", 32'(select), 32'h3);
      tk = 0;
      repeat (40) begin
         @(negedge clk);
         if (frame_tick) tk++;
      end
      check("dis_no_tick", 32'(tk), 32'd0);
      digits_in = 8'h9C;
      digit_en  = 2'b01;
      @(negedge clk);
      check("reen_val", 32'(digit_val), 32'hC);
      check("reen_blank", 32'(select), 32'h3);

      // mid-slot input change
      digits_in = 8'h73;
      digit_en  = 2'b11;
      wait_tick();
      repeat (6) @(negedge clk);
      digits_in  = 8'h5A;
      brightness = 4'd2;
      @(negedge clk);
      check("mid_val_held", 32'(digit_val), 32'h3);
      repeat (20) @(negedge clk);
      check("mid_on_held", 32'(select), 32'h2);

      // reset mid-operation
      digits_in  = 8'h73;
      brightness = 4'd15;
      wait_tick();
      repeat (6) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("mrst_sel", 32'(select), 32'h3);
      check("mrst_val", 32'(digit_val), 32'h0);
      check("mrst_tick", 32'(frame_tick), 32'h0);
      reset_n = 1'b1;
      @(negedge clk);
      check("mrst_first_d0", 32'(digit_val), 32'h3);
      repeat (4) @(negedge clk);
      check("mrst_on_d0", 32'(select), 32'h2);

      // randomized stimulus
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         reset_n = 1'b1;
         if ($urandom_range(19, 0) == 0) digits_in = 8'($urandom);
         if ($urandom_range(29, 0) == 0) brightness = 4'($urandom);
         if ($urandom_range(79, 0) == 0) digit_en = 2'($urandom);
         if ($urandom_range(599, 0) == 0) reset_n = 1'b0;
      end
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
